pipe_add16_seq: RTL and testbench

PIPE_ADD16_SEQ -- requirements
Module: pipe_add16_seq

---
 rtl/pipe_add16_seq_pkg.sv | 19 +
 rtl/pipe_add16_seq_if.sv | 30 +++
 rtl/pipe_add16_seq.sv | 112 +++++++++++
 tb/tb_pipe_add16_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add16_seq_pkg.sv
// Shared widths, FSM encoding and default adder latency for the nibble-serial
// 16-bit adder sequencer.
package pipe_add16_seq_pkg;

    localparam int NIB_W         = 4;
    localparam int NIB_N         = 4;
    localparam int DATA_W        = NIB_W * NIB_N;
    localparam int IDX_W         = 2;
    localparam int CNT_W         = 4;
    localparam int ADDER_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_add16_seq_if.sv
// Request/response bus plus the nibble link to the external 4-bit pipelined
// adder; slave is the sequencer side, master the surrounding logic.
interface pipe_add16_seq_if;
    import pipe_add16_seq_pkg::*;

    logic              Start;
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic              Cin_in;
    logic              Ready;
    logic              Done;
    logic [DATA_W-1:0] Result;
    logic              Cout_out;
    logic [NIB_W-1:0]  Add_A;
    logic [NIB_W-1:0]  Add_B;
    logic              Add_Cin;
    logic [NIB_W-1:0]  Add_Sum;
    logic              Add_Cout;

    modport slave (
        input  Start, A_in, B_in, Cin_in, Add_Sum, Add_Cout,
        output Ready, Done, Result, Cout_out, Add_A, Add_B, Add_Cin
    );

    modport master (
        output Start, A_in, B_in, Cin_in, Add_Sum, Add_Cout,
        input  Ready, Done, Result, Cout_out, Add_A, Add_B, Add_Cin
    );

endinterface

// File: rtl/pipe_add16_seq.sv
// Sequences a 16-bit add as four nibble adds through an external pipelined
// 4-bit adder, rippling the returned carry from nibble to nibble.
module pipe_add16_seq
    import pipe_add16_seq_pkg::*;
#(
    parameter int ADDER_LAT = ADDER_LAT_DEF
) (
    input  logic            Clk,
    input  logic            Rst_n,
    pipe_add16_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ADDER_LAT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              cout_q, cout_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [IDX_W+1:0]  nib_lsb;

    assign nib_lsb = {idx_q, 2'b00};

    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous, so Rst_n is tested only inside the clocked block.
        if (!Rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    // NOTE: operand holding registers need no reset; they are only read after a capture.
    always_ff @(posedge Clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        result_d = result_q;
        cout_d   = cout_q;
        a_d      = a_q;
        b_d      = b_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    a_d     = bus.A_in;
                    b_d     = bus.B_in;
                    carry_d = bus.Cin_in;
                    idx_d   = '0;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // The adder's answer for this nibble is valid only when the count expires.
                if (cnt_q == '0) begin
                    sum_d[nib_lsb +: NIB_W] = bus.Add_Sum;
                    carry_d                 = bus.Add_Cout;
                    if (idx_q == IDX_W'(NIB_N - 1)) begin
                        result_d = sum_d;
                        cout_d   = bus.Add_Cout;
                        state_d  = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Ready    = (state_q == IDLE) || (state_q == DONE);
    assign bus.Done     = (state_q == DONE);
    assign bus.Result   = result_q;
    assign bus.Cout_out = cout_q;
    assign bus.Add_A    = (state_q == ISSUE) ? a_q[nib_lsb +: NIB_W] : '0;
    assign bus.Add_B    = (state_q == ISSUE) ? b_q[nib_lsb +: NIB_W] : '0;
    assign bus.Add_Cin  = (state_q == ISSUE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_pipe_add16_seq.sv
// Randomised and directed bench for pipe_add16_seq at ADDER_LAT 4 and 1,
// each DUT paired with a behavioural pipelined 4-bit adder.
module tb_pipe_add16_seq;
    import pipe_add16_seq_pkg::*;

    logic Clk = 1'b0;
    logic Rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    pipe_add16_seq_if if4 ();
    pipe_add16_seq_if if1 ();

    pipe_add16_seq #(.ADDER_LAT(4)) dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(if4.slave));
    pipe_add16_seq #(.ADDER_LAT(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(if1.slave));

    // External adders: result appears LAT cycles after the operands.
    logic [4:0] pipe4 [0:3];
    logic [4:0] pipe1;

    always @(posedge Clk) begin
        pipe4[0] <= 5'(if4.Add_A) + 5'(if4.Add_B) + 5'(if4.Add_Cin);
        for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
        pipe1 <= 5'(if1.Add_A) + 5'(if1.Add_B) + 5'(if1.Add_Cin);
    end

    assign if4.Add_Sum  = pipe4[3][3:0];
    assign if4.Add_Cout = pipe4[3][4];
    assign if1.Add_Sum  = pipe1[3:0];
    assign if1.Add_Cout = pipe1[4];

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + 17'(cin);
    endfunction

    // Presents one request, then counts cycles until Done (lat = -1 on timeout).
    task automatic do_add(input bit use1, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output int lat, output logic [16:0] res);
        @(negedge Clk);
        if (use1) begin
            if1.Start = 1'b1; if1.A_in = a; if1.B_in = b; if1.Cin_in = cin;
        end else begin
            if4.Start = 1'b1; if4.A_in = a; if4.B_in = b; if4.Cin_in = cin;
        end
        @(negedge Clk);
        if1.Start = 1'b0;
        if4.Start = 1'b0;
        lat = -1;
        res = 'x;
        for (int n = 1; n <= 100; n++) begin
            if (use1 ? if1.Done : if4.Done) begin
                lat = n;
                res = use1 ? {if1.Cout_out, if1.Result} : {if4.Cout_out, if4.Result};
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        n_checks++;
        if (if4.Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready4 got=%b exp=1", if4.Ready); end
        n_checks++;
        if (if4.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got=%b exp=0", if4.Done); end
        n_checks++;
        if ({if4.Cout_out, if4.Result} !== 17'h0) begin
            n_fail++; $display("FAIL reset_result4 got=%h exp=0", {if4.Cout_out, if4.Result});
        end
        n_checks++;
        if (if1.Ready !== 1'b1 || if1.Done !== 1'b0 || {if1.Cout_out, if1.Result} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_dut1 got ready=%b done=%b res=%h exp 1/0/0",
                     if1.Ready, if1.Done, {if1.Cout_out, if1.Result});
        end
    endtask

    task automatic test_directed();
        logic [15:0] av [3] = '{16'h7777, 16'hFFFF, 16'hA4A4};
        logic [15:0] bv [3] = '{16'h5555, 16'h0001, 16'h6A6A};
        logic        cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [16:0] ev [3] = '{17'h0CCCC, 17'h10000, 17'h10F0F};
        int          lat;
        logic [16:0] res;
        for (int i = 0; i < 3; i++) begin
            do_add(1'b0, av[i], bv[i], cv[i], lat, res);
            n_checks++;
            if (res !== ev[i]) begin
                n_fail++; $display("FAIL directed%0d_sum got=%h exp=%h", i, res, ev[i]);
            end
            n_checks++;
            if (lat !== 21) begin
                n_fail++; $display("FAIL directed%0d_latency got=%0d exp=21", i, lat);
            end
        end
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({if4.Cout_out, if4.Result} !== 17'h10F0F || if4.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL result_hold got=%h done=%b exp=10f0f done=0",
                     {if4.Cout_out, if4.Result}, if4.Done);
        end
    endtask

    task automatic test_lat1();
        int          lat;
        logic [16:0] res;
        do_add(1'b1, 16'h1234, 16'h4321, 1'b1, lat, res);
        n_checks++;
        if (res !== 17'h05556) begin n_fail++; $display("FAIL lat1_sum got=%h exp=05556", res); end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL lat1_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_random();
        int          lat;
        logic [16:0] res;
        logic [16:0] exp;
        logic [15:0] a, b;
        logic        cin;
        for (int i = 0; i < 24; i++) begin
            bit use1 = (i >= 16);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            exp = ref_add(a, b, cin);
            do_add(use1, a, b, cin, lat, res);
            n_checks++;
            if (res !== exp) begin
                n_fail++; $display("FAIL random%0d_sum a=%h b=%h cin=%b got=%h exp=%h",
                                   i, a, b, cin, res, exp);
            end
            n_checks++;
            if (lat !== (use1 ? 9 : 21)) begin
                n_fail++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, use1 ? 9 : 21);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          done_cnt = 0;
        int          first_done = -1;
        int          second_done = -1;
        logic [16:0] r1 = 'x, r2 = 'x;
        logic [16:0] exp1, exp2 = 'x;
        logic        ready_mid = 'x;
        @(negedge Clk);
        if4.Start = 1'b1; if4.A_in = 16'h1357; if4.B_in = 16'h2468; if4.Cin_in = 1'b1;
        exp1 = ref_add(16'h1357, 16'h2468, 1'b1);
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clk);
            if (if4.Done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = n; r1 = {if4.Cout_out, if4.Result};
                end else begin
                    second_done = n; r2 = {if4.Cout_out, if4.Result};
                end
            end
            if (n == 5) ready_mid = if4.Ready;
            if (n <= 21) begin
                if4.Start  = 1'b1;
                if4.A_in   = 16'($urandom);
                if4.B_in   = 16'($urandom);
                if4.Cin_in = 1'($urandom);
                if (n == 21) exp2 = ref_add(if4.A_in, if4.B_in, if4.Cin_in);
            end else begin
                if4.Start = 1'b0;
            end
        end
        n_checks++;
        if (ready_mid !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy got=%b exp=0", ready_mid); end
        n_checks++;
        if (first_done !== 21 || r1 !== exp1) begin
            n_fail++; $display("FAIL b2b_first got cyc=%0d res=%h exp cyc=21 res=%h", first_done, r1, exp1);
        end
        n_checks++;
        if (second_done !== 42 || r2 !== exp2) begin
            n_fail++; $display("FAIL b2b_second got cyc=%0d res=%h exp cyc=42 res=%h", second_done, r2, exp2);
        end
        n_checks++;
        if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          stray = 0;
        logic [16:0] res;
        @(negedge Clk);
        if4.Start = 1'b1; if4.A_in = 16'h7777; if4.B_in = 16'h5555; if4.Cin_in = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            @(negedge Clk);
            if4.Start = 1'b0;
            if (if4.Done) stray++;
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        n_checks++;
        if (if4.Ready !== 1'b1 || if4.Done !== 1'b0 || {if4.Cout_out, if4.Result} !== 17'h0) begin
            n_fail++;
            $display("FAIL midreset_state got ready=%b done=%b res=%h exp 1/0/0",
                     if4.Ready, if4.Done, {if4.Cout_out, if4.Result});
        end
        for (int n = 0; n < 30; n++) begin
            @(negedge Clk);
            if (if4.Done) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", stray); end
        do_add(1'b0, 16'h0003, 16'h0000, 1'b0, lat, res);
        n_checks++;
        if (res !== 17'h00003 || lat !== 21) begin
            n_fail++; $display("FAIL midreset_next got res=%h lat=%0d exp res=00003 lat=21", res, lat);
        end
    endtask

    initial begin
        Rst_n      = 1'b0;
        if4.Start  = 1'b0; if4.A_in = '0; if4.B_in = '0; if4.Cin_in = 1'b0;
        if1.Start  = 1'b0; if1.A_in = '0; if1.B_in = '0; if1.Cin_in = 1'b0;
        test_reset();
        test_directed();
        test_lat1();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
